// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with a Moore match flag and a saturating match counter.
// Overlapping or non-overlapping matching is chosen at elaboration time.
module seq_detect_param #(
    parameter int unsigned          PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1100,
    parameter bit                   OVERLAP = 1'b1,
    parameter int unsigned          CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             seq_in,
    input  logic             clear_cnt,
    output logic             seq_out,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat
);

    localparam int unsigned          FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0]    FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]     CNT_MAX   = {CNT_W{1'b1}};

    logic [PAT_LEN-1:0] hist_q;
    logic [PAT_LEN-1:0] hist_d;
    logic [PAT_LEN-1:0] hist_shift_c;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_d;
    logic [FILL_W-1:0]  fill_inc_c;
    logic               seq_out_d;
    logic [CNT_W-1:0]   match_count_d;
    logic               cnt_sat_d;
    logic               match_c;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist_q      <= '0;
            fill_q      <= '0;
            seq_out     <= 1'b0;
            match_count <= '0;
            cnt_sat     <= 1'b0;
        end else begin
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            seq_out     <= seq_out_d;
            match_count <= match_count_d;
            cnt_sat     <= cnt_sat_d;
        end
    end

    // Next-state: history shift, fill tracking, match detection and counter update
    always_comb begin
        hist_d        = hist_q;
        fill_d        = fill_q;
        seq_out_d     = seq_out;
        match_count_d = match_count;
        cnt_sat_d     = cnt_sat;

        // The oldest bit falls off the top of the history when a new one is shifted in.
        hist_shift_c  = PAT_LEN'({hist_q, seq_in});
        fill_inc_c    = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        match_c       = enable && (fill_inc_c == FILL_FULL) && (hist_shift_c == PATTERN);

        if (enable) begin
            hist_d    = hist_shift_c;
            fill_d    = (match_c && !OVERLAP) ? '0 : fill_inc_c;
            seq_out_d = match_c;
        end

        // A clear coincident with a match counts that match as the first after the clear.
        if (clear_cnt) begin
            match_count_d = match_c ? CNT_W'(1) : '0;
            cnt_sat_d     = 1'b0;
        end else if (match_c && (match_count != CNT_MAX)) begin
            match_count_d = match_count + CNT_W'(1);
            cnt_sat_d     = cnt_sat | (match_count_d == CNT_MAX);
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: four parameterisations share one stimulus stream and are
// checked against directed tables, hand sequences and a bit-log reference model.
module tb_seq_detect_param;

    localparam int PL = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       seq_in;
    logic       clear_cnt;

    logic       so_w  [4];
    logic       sat_w [4];
    logic [7:0] cnt_w [4];
    logic [1:0] cnt_d;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // Reference model state: log of accepted bits since last restart, matches since clear
    int pats    [4] = '{12, 10, 10, 12};
    bit ovl     [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int cmax    [4] = '{255, 255, 255, 3};
    bit bit_log [4][32];
    int n_acc   [4];
    int mcnt    [4];
    bit m_so    [4];

    typedef struct {
        logic en;
        logic din;
        logic clr;
        logic exp_so;
        int   exp_cnt;
    } vec_t;

    vec_t tbl [16];

    always #5 clock = ~clock;

    seq_detect_param u_a (
        .clock(clock), .reset(reset), .enable(enable), .seq_in(seq_in), .clear_cnt(clear_cnt),
        .seq_out(so_w[0]), .match_count(cnt_w[0]), .cnt_sat(sat_w[0])
    );
    seq_detect_param #(.PATTERN(4'b1010), .OVERLAP(1'b1)) u_b (
        .clock(clock), .reset(reset), .enable(enable), .seq_in(seq_in), .clear_cnt(clear_cnt),
        .seq_out(so_w[1]), .match_count(cnt_w[1]), .cnt_sat(sat_w[1])
    );
    seq_detect_param #(.PATTERN(4'b1010), .OVERLAP(1'b0)) u_c (
        .clock(clock), .reset(reset), .enable(enable), .seq_in(seq_in), .clear_cnt(clear_cnt),
        .seq_out(so_w[2]), .match_count(cnt_w[2]), .cnt_sat(sat_w[2])
    );
    seq_detect_param #(.CNT_W(2)) u_d (
        .clock(clock), .reset(reset), .enable(enable), .seq_in(seq_in), .clear_cnt(clear_cnt),
        .seq_out(so_w[3]), .match_count(cnt_d), .cnt_sat(sat_w[3])
    );
    assign cnt_w[3] = {6'b0, cnt_d};

    task automatic check(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            n_acc[i] = 0;
            mcnt[i]  = 0;
            m_so[i]  = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        bit m;
        m = 1'b0;
        if (enable) begin
            bit_log[i][n_acc[i] % 32] = seq_in;
            n_acc[i]++;
            if (n_acc[i] >= PL) begin
                m = 1'b1;
                for (int k = 0; k < PL; k++)
                    if (bit_log[i][(n_acc[i] - PL + k) % 32] != bit'((pats[i] >> (PL - 1 - k)) & 1))
                        m = 1'b0;
            end
            if (m && !ovl[i]) n_acc[i] = 0;
            m_so[i] = m;
        end
        if (clear_cnt) mcnt[i] = int'(m);
        else           mcnt[i] = mcnt[i] + int'(m);
    endtask

    task automatic check_model(input string name);
        int ec;
        for (int i = 0; i < 4; i++) begin
            ec = (mcnt[i] > cmax[i]) ? cmax[i] : mcnt[i];
            check($sformatf("%s_so%0d", name, i), int'(so_w[i]), int'(m_so[i]));
            check($sformatf("%s_cnt%0d", name, i), int'(cnt_w[i]), ec);
            check($sformatf("%s_sat%0d", name, i), int'(sat_w[i]), int'(mcnt[i] >= cmax[i]));
        end
    endtask

    // One clock: inputs applied just after an edge, outputs sampled 1 unit after the next edge
    task automatic cyc(input logic en, input logic din, input logic clr);
        enable    = en;
        seq_in    = din;
        clear_cnt = clr;
        @(posedge clock);
        for (int i = 0; i < 4; i++) model_step(i);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #4;
        reset = 1'b1;
    endtask

    task automatic feed4(input logic [3:0] bits, input logic clr_last);
        for (int k = 3; k >= 0; k--) cyc(1'b1, bits[k], (k == 0) ? clr_last : 1'b0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 2};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 2};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 0};

        reset     = 1'b0;
        enable    = 1'b0;
        seq_in    = 1'b0;
        clear_cnt = 1'b0;
        model_reset();
        #12;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_so%0d", i), int'(so_w[i]), 0);
            check($sformatf("rst_cnt%0d", i), int'(cnt_w[i]), 0);
            check($sformatf("rst_sat%0d", i), int'(sat_w[i]), 0);
        end
        reset = 1'b1;

        // Directed table on the default instance
        for (int t = 0; t < 16; t++) begin
            cyc(tbl[t].en, tbl[t].din, tbl[t].clr);
            check($sformatf("tbl%0d_so", t), int'(so_w[0]), int'(tbl[t].exp_so));
            check($sformatf("tbl%0d_cnt", t), int'(cnt_w[0]), tbl[t].exp_cnt);
            check($sformatf("tbl%0d_sat", t), int'(sat_w[0]), 0);
        end

        // Overlapping versus non-overlapping 1010 detection
        do_reset();
        begin
            logic [5:0] bits  = 6'b101010;
            logic [5:0] exp_b = 6'b000101;
            logic [5:0] exp_c = 6'b000100;
            for (int k = 0; k < 6; k++) begin
                cyc(1'b1, bits[5 - k], 1'b0);
                check($sformatf("ovl_b%0d", k), int'(so_w[1]), int'(exp_b[5 - k]));
                check($sformatf("ovl_c%0d", k), int'(so_w[2]), int'(exp_c[5 - k]));
            end
        end
        check("ovl_b_cnt", int'(cnt_w[1]), 2);
        check("ovl_c_cnt", int'(cnt_w[2]), 1);

        // Counter saturation with a 2-bit counter, then clear coincident with a match
        do_reset();
        for (int m = 0; m < 4; m++) feed4(4'b1100, 1'b0);
        check("sat_cnt", int'(cnt_w[3]), 3);
        check("sat_flag", int'(sat_w[3]), 1);
        feed4(4'b1100, 1'b1);
        check("clr_match_cnt", int'(cnt_w[3]), 1);
        check("clr_match_sat", int'(sat_w[3]), 0);
        check("clr_match_so", int'(so_w[3]), 1);

        // Reset pulsed mid-pattern discards partial history
        do_reset();
        feed4(4'b1100, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        model_reset();
        #2;
        check("midrst_so", int'(so_w[0]), 0);
        check("midrst_cnt", int'(cnt_w[0]), 0);
        check("midrst_sat", int'(sat_w[0]), 0);
        #3;
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        check("postrst_so", int'(so_w[0]), 0);
        check("postrst_cnt", int'(cnt_w[0]), 0);
        feed4(4'b1100, 1'b0);
        check("postrst_match_so", int'(so_w[0]), 1);
        check("postrst_match_cnt", int'(cnt_w[0]), 1);

        // Randomised stimulus against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                check_model("rnd_rst");
            end
            cyc(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 59) == 0));
            check_model("rnd");
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Parameters
REQ-001 The block SHALL have parameter PAT_LEN, default 4, giving the pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter PATTERN, default 4'b1100, giving the target pattern; the MSB is the first bit received.
REQ-003 The block SHALL have parameter OVERLAP, default 1, where 1 means overlapping matches are allowed and 0 means they are not.
REQ-004 The block SHALL have parameter CNT_W, default 8, giving the width of the match counter.

Interface
REQ-005 The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port enable, input, 1 bit: qualifies seq_in; a bit is "accepted" only in cycles where enable=1.
REQ-008 The block SHALL have port seq_in, input, 1 bit: serial data bit.
REQ-009 The block SHALL have port clear_cnt, input, 1 bit: synchronous clear of match_count and cnt_sat.
REQ-010 The block SHALL have port seq_out, output, 1 bit: registered Moore match flag.
REQ-011 The block SHALL have port match_count, output, CNT_W bits: number of matches since reset or clear.
REQ-012 The block SHALL have port cnt_sat, output, 1 bit: sticky flag, set when match_count is saturated.

Function
REQ-013 The block SHALL hold a history register hist[PAT_LEN-1:0] and a fill counter fill (0..PAT_LEN).
REQ-014 On an accepted bit, the block SHALL set hist to {hist[PAT_LEN-2:0], seq_in} and fill to min(fill+1, PAT_LEN).
REQ-015 A match SHALL be declared on an accepted bit when the next fill equals PAT_LEN and the next hist equals PATTERN.
REQ-016 seq_out SHALL update only on accepted bits: 1 on the clock edge following a matching bit (latency 1 clock), otherwise 0.
REQ-017 seq_out SHALL hold its value through cycles with enable=0 (Moore behaviour: the output reflects state, not input).
REQ-018 With OVERLAP=1, hist and fill SHALL be retained after a match, so a suffix of the pattern may begin the next match.
REQ-019 With OVERLAP=0, a matching bit SHALL set fill to 0, so the next match needs PAT_LEN further accepted bits.
REQ-020 No match SHALL be declared while fill < PAT_LEN, regardless of the hist contents.
REQ-021 On each match, match_count SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-022 cnt_sat SHALL set when match_count reaches 2^CNT_W-1 and remain set until reset or clear_cnt.
REQ-023 When clear_cnt=1 and no match occurs in that cycle, match_count and cnt_sat SHALL become 0.
REQ-024 When clear_cnt=1 and a match occurs in the same cycle, match_count SHALL become 1 and cnt_sat SHALL become 0.
REQ-025 clear_cnt SHALL NOT affect hist, fill or seq_out.
REQ-026 Bits presented with enable=0 SHALL be ignored entirely; no state SHALL change except through clear_cnt.

Reset
REQ-027 When reset=0, the block SHALL immediately (asynchronously) force hist=0, fill=0, seq_out=0, match_count=0 and cnt_sat=0.
REQ-028 Reset asserted mid-pattern SHALL discard partial history; after reset releases, a full PAT_LEN accepted bits SHALL be needed for a match.
REQ-029 Reset release SHALL be sampled synchronously; the first bit can be accepted on the first rising edge with reset=1.

Verification
REQ-030 Defaults, enable=1, seq_in 1,1,0,0 -> seq_out=1 for the one cycle after the 4th bit; match_count=1.
REQ-031 PATTERN=4'b1010, OVERLAP=1, bits 1,0,1,0,1,0 -> seq_out pulses after bits 4 and 6; match_count=2.
REQ-032 PATTERN=4'b1010, OVERLAP=0, same bits -> seq_out pulses after bit 4 only; match_count=1.
REQ-033 Defaults, bits 1,1 then enable=0 for 3 cycles (seq_in toggling), then 0,0 -> match after the 4th accepted bit; seq_out holds 1 while enable=0 afterwards.
REQ-034 CNT_W=2, 4 matches -> match_count=3 and cnt_sat=1; then clear_cnt coincident with a 5th match -> match_count=1, cnt_sat=0.
REQ-035 Bits 1,1,0, reset pulsed low for half a cycle, then 0 -> no match; all outputs 0 during reset.
